// File: rtl/free_list.sv
// free_list: circular free list of physical register tags for a 3-wide
// rename stage. It hands out up to three new tags per cycle, takes back up to
// three retired old tags per cycle, and on branch recovery reclaims every
// in-flight allocation at once by moving head onto tail.
//
// Allocate handshake: alloc_req[i] is the request and alloc_gnt[i] is the
// acknowledge. A tag is consumed only when req and gnt are both 1 at a posedge
// with no recovery. Grants always form a prefix of the requesting slots.
// alloc_pr/alloc_gnt are combinational, so they may depend on alloc_req in the
// same cycle. Retire has no back-pressure: every retire_valid bit is accepted.
module free_list #(
   parameter int  NPR   = 64,
   parameter int  NARCH = 32,
   localparam int PR    = $clog2(NPR),
   localparam int NFL   = NPR - NARCH,
   localparam int IW    = $clog2(NFL),
   localparam int CW    = IW + 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [2:0]         alloc_req,
   output logic [2:0][PR-1:0] alloc_pr,
   output logic [2:0]         alloc_gnt,
   output logic [CW-1:0]      free_count,
   input  logic [2:0]         retire_valid,
   input  logic [2:0][PR-1:0] retire_told,
   input  logic               BPRecoverEN
);

   // Number of set bits in a 3-bit vector.
   function automatic logic [1:0] pop3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   // Tag storage and pointers. Slots [tail, head) hold in-flight tags in
   // program order; slots [head, tail) hold free tags in allocation order.
   logic [PR-1:0]   fl_buf [NFL];
   logic [IW-1:0]   head;
   logic [IW-1:0]   tail;
   logic [CW-1:0]   count;

   logic [2:0][1:0] alloc_off;
   logic [2:0][1:0] retire_off;
   logic [1:0]      gnt_num;
   logic [1:0]      ret_num;
   logic [IW-1:0]   tail_next;
   logic [CW-1:0]   count_next;

   // Offsets: each slot counts only the requesting/valid slots older than it,
   // so the requesters are packed onto consecutive buffer entries.
   always_comb begin
      alloc_off  = '0;
      retire_off = '0;
      alloc_off[1]  = {1'b0, alloc_req[0]};
      alloc_off[2]  = pop3({1'b0, alloc_req[1:0]});
      retire_off[1] = {1'b0, retire_valid[0]};
      retire_off[2] = pop3({1'b0, retire_valid[1:0]});
   end

   // Offer tags from head onward; grant while the packed offset is below the
   // number of free entries.
   always_comb begin
      alloc_pr  = '0;
      alloc_gnt = '0;
      for (int i = 0; i < 3; i++) begin
         alloc_pr[i]  = fl_buf[head + IW'(alloc_off[i])];
         alloc_gnt[i] = alloc_req[i] && (CW'(alloc_off[i]) < count);
      end
   end

   // Next-state arithmetic for pointers and occupancy.
   always_comb begin
      gnt_num    = pop3(alloc_gnt);
      ret_num    = pop3(retire_valid);
      tail_next  = tail + IW'(ret_num);
      count_next = count - CW'(gnt_num) + CW'(ret_num);
   end

   // Pointer and occupancy registers. Recovery keeps this cycle's retires,
   // drops this cycle's grants, and makes every slot free again.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= CW'(NFL);
      end else begin
         tail <= tail_next;
         if (BPRecoverEN) begin
            head  <= tail_next;
            count <= CW'(NFL);
         end else begin
            head  <= head + IW'(gnt_num);
            count <= count_next;
         end
      end
   end

   // Tag storage: starts with the tags above the architectural range; retired
   // old tags are written packed from tail.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NFL; k++) begin
            fl_buf[k] <= PR'(NARCH + k);
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (retire_valid[i]) begin
               fl_buf[tail + IW'(retire_off[i])] <= retire_told[i];
            end
         end
      end
   end

   assign free_count = count;

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and randomized checks of free_list against a
// queue-based model (free tags queue + in-flight tags queue).
module tb_free_list;

   localparam int PR  = 6;
   localparam int NFL = 32;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [2:0]         alloc_req = '0;
   logic [2:0][PR-1:0] alloc_pr;
   logic [2:0]         alloc_gnt;
   logic [5:0]         free_count;
   logic [2:0]         retire_valid = '0;
   logic [2:0][PR-1:0] retire_told = '0;
   logic               BPRecoverEN = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: exp_q holds free tags in allocation order, infl_q holds in-flight
   // tags in program order.
   logic [PR-1:0] exp_q[$];
   logic [PR-1:0] infl_q[$];
   logic [2:0]    exp_gnt;
   logic [PR-1:0] exp_pr[3];

   free_list #(.NPR(64), .NARCH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .alloc_req    (alloc_req),
      .alloc_pr     (alloc_pr),
      .alloc_gnt    (alloc_gnt),
      .free_count   (free_count),
      .retire_valid (retire_valid),
      .retire_told  (retire_told),
      .BPRecoverEN  (BPRecoverEN)
   );

   // Clock generation.
   always #5 clock = ~clock;

   // Safety net against a hung run.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      exp_q.delete();
      infl_q.delete();
      for (int k = 0; k < NFL; k++) exp_q.push_back(PR'(32 + k));
   endtask

   task automatic do_reset();
      alloc_req    = '0;
      retire_valid = '0;
      retire_told  = '0;
      BPRecoverEN  = 1'b0;
      reset = 1'b1;
      #12;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   // Drive one cycle's inputs, let them settle, and compute expected grants.
   task automatic apply(input logic [2:0] req, input logic [2:0] rv,
                        input logic [PR-1:0] t0, input logic [PR-1:0] t1,
                        input logic [PR-1:0] t2, input logic rec);
      int k;
      alloc_req      = req;
      retire_valid   = rv;
      retire_told[0] = t0;
      retire_told[1] = t1;
      retire_told[2] = t2;
      BPRecoverEN    = rec;
      #1;
      k = 0;
      exp_gnt = '0;
      for (int i = 0; i < 3; i++) begin
         exp_pr[i] = '0;
         if (req[i]) begin
            if (k < exp_q.size()) begin
               exp_gnt[i] = 1'b1;
               exp_pr[i]  = exp_q[k];
            end
            k++;
         end
      end
   endtask

   // Clock edge plus model update from the inputs held over that edge.
   task automatic step();
      int ng;
      logic [PR-1:0] tmp;
      ng = 0;
      for (int i = 0; i < 3; i++) if (exp_gnt[i]) ng++;
      @(posedge clock);
      if (!BPRecoverEN)
         for (int j = 0; j < ng; j++) infl_q.push_back(exp_q.pop_front());
      for (int i = 0; i < 3; i++) begin
         if (retire_valid[i]) begin
            if (infl_q.size() > 0) tmp = infl_q.pop_front();
            exp_q.push_back(retire_told[i]);
         end
      end
      if (BPRecoverEN) begin
         for (int j = infl_q.size() - 1; j >= 0; j--) exp_q.push_front(infl_q[j]);
         infl_q.delete();
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      n_checks++;
      if (free_count !== 6'd32) begin
         n_fail++; $display("FAIL reset_count: got %0d expected 32", free_count);
      end
      do_reset();
      apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (alloc_gnt !== 3'b111) begin
         n_fail++; $display("FAIL reset_gnt: got %b expected 111", alloc_gnt);
      end
      n_checks++;
      if (alloc_pr[0] !== 6'd32 || alloc_pr[1] !== 6'd33 || alloc_pr[2] !== 6'd34) begin
         n_fail++; $display("FAIL reset_pr: got %0d,%0d,%0d expected 32,33,34",
                            alloc_pr[0], alloc_pr[1], alloc_pr[2]);
      end
      step();
      apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd29) begin
         n_fail++; $display("FAIL first_alloc_count: got %0d expected 29", free_count);
      end
      n_checks++;
      if (alloc_pr[0] !== 6'd35) begin
         n_fail++; $display("FAIL first_alloc_pr0: got %0d expected 35", alloc_pr[0]);
      end
      step();
   endtask

   task automatic test_sparse_req();
      do_reset();
      apply(3'b101, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (alloc_gnt !== 3'b101) begin
         n_fail++; $display("FAIL sparse_gnt: got %b expected 101", alloc_gnt);
      end
      n_checks++;
      if (alloc_pr[0] !== 6'd32 || alloc_pr[2] !== 6'd33) begin
         n_fail++; $display("FAIL sparse_pr: got %0d,%0d expected 32,33", alloc_pr[0], alloc_pr[2]);
      end
      step();
      apply(3'b001, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd30 || alloc_pr[0] !== 6'd34) begin
         n_fail++; $display("FAIL sparse_head: got count %0d pr0 %0d expected 30, 34",
                            free_count, alloc_pr[0]);
      end
      step();
   endtask

   task automatic test_drain();
      do_reset();
      repeat (10) begin
         apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
         step();
      end
      apply(3'b001, 3'b000, 0, 0, 0, 1'b0);
      step();
      apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd1 || alloc_gnt !== 3'b001 || alloc_pr[0] !== 6'd63) begin
         n_fail++; $display("FAIL drain_last: got count %0d gnt %b pr0 %0d expected 1 001 63",
                            free_count, alloc_gnt, alloc_pr[0]);
      end
      step();
      apply(3'b111, 3'b011, 6'd5, 6'd7, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd0 || alloc_gnt !== 3'b000) begin
         n_fail++; $display("FAIL drain_empty: got count %0d gnt %b expected 0 000",
                            free_count, alloc_gnt);
      end
      step();
      apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd2 || alloc_gnt !== 3'b011 ||
          alloc_pr[0] !== 6'd5 || alloc_pr[1] !== 6'd7) begin
         n_fail++; $display("FAIL drain_refill: got count %0d gnt %b pr %0d,%0d expected 2 011 5,7",
                            free_count, alloc_gnt, alloc_pr[0], alloc_pr[1]);
      end
      step();
   endtask

   task automatic test_recovery();
      logic [PR-1:0] seq[$];
      int idx;
      do_reset();
      repeat (3) begin
         apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
         step();
      end
      apply(3'b001, 3'b000, 0, 0, 0, 1'b0);
      step();
      apply(3'b000, 3'b111, 6'd1, 6'd2, 6'd3, 1'b0);
      step();
      apply(3'b000, 3'b001, 6'd4, 0, 0, 1'b0);
      step();
      apply(3'b111, 3'b001, 6'd9, 0, 0, 1'b1);
      step();
      for (int t = 37; t <= 63; t++) seq.push_back(PR'(t));
      seq.push_back(6'd1); seq.push_back(6'd2); seq.push_back(6'd3);
      seq.push_back(6'd4); seq.push_back(6'd9);
      apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd32) begin
         n_fail++; $display("FAIL recover_count: got %0d expected 32", free_count);
      end
      idx = 0;
      repeat (11) begin
         for (int i = 0; i < 3; i++) begin
            if (alloc_gnt[i]) begin
               n_checks++;
               if (idx >= 32) begin
                  n_fail++; $display("FAIL recover_extra_gnt: slot %0d granted tag %0d beyond 32",
                                     i, alloc_pr[i]);
               end else if (alloc_pr[i] !== seq[idx]) begin
                  n_fail++; $display("FAIL recover_order[%0d]: got %0d expected %0d",
                                     idx, alloc_pr[i], seq[idx]);
               end
               idx++;
            end
         end
         step();
         apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
      end
      n_checks++;
      if (idx != 32) begin
         n_fail++; $display("FAIL recover_total: got %0d grants expected 32", idx);
      end
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (6) begin
         apply(3'b111, 3'b000, 0, 0, 0, 1'b0);
         step();
      end
      apply(3'b011, 3'b000, 0, 0, 0, 1'b0);
      step();
      apply(3'b001, 3'b000, 0, 0, 0, 1'b0);
      n_checks++;
      if (free_count !== 6'd12) begin
         n_fail++; $display("FAIL async_pre_count: got %0d expected 12", free_count);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (free_count !== 6'd32 || alloc_pr[0] !== 6'd32 || alloc_gnt[0] !== 1'b1) begin
         n_fail++; $display("FAIL async_reset: got count %0d pr0 %0d gnt0 %b expected 32 32 1",
                            free_count, alloc_pr[0], alloc_gnt[0]);
      end
      model_reset();
      alloc_req = '0;
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   // Random traffic against the model; recovery pulses only when rec_en.
   task automatic test_random(input int cycles, input bit rec_en);
      logic [2:0] req, rv;
      int nr;
      logic rec;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         req = 3'($urandom_range(0, 7));
         rv = '0;
         nr = 0;
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1 && nr < infl_q.size()) begin
               rv[i] = 1'b1;
               nr++;
            end
         end
         rec = rec_en && ($urandom_range(0, 15) == 0);
         apply(req, rv, PR'($urandom_range(0, 63)), PR'($urandom_range(0, 63)),
               PR'($urandom_range(0, 63)), rec);
         n_checks++;
         if (alloc_gnt !== exp_gnt) begin
            n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, alloc_gnt, exp_gnt);
         end
         for (int i = 0; i < 3; i++) begin
            if (exp_gnt[i]) begin
               n_checks++;
               if (alloc_pr[i] !== exp_pr[i]) begin
                  n_fail++; $display("FAIL rand_pr c%0d slot%0d: got %0d expected %0d",
                                     c, i, alloc_pr[i], exp_pr[i]);
               end
            end
         end
         n_checks++;
         if (free_count !== 6'(exp_q.size())) begin
            n_fail++; $display("FAIL rand_count c%0d: got %0d expected %0d",
                               c, free_count, exp_q.size());
         end
         n_checks++;
         if (free_count > 6'd32) begin
            n_fail++; $display("FAIL count_bound c%0d: got %0d expected <= 32", c, free_count);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_sparse_req();
      test_drain();
      test_recovery();
      test_async_reset();
      test_random(60, 1'b0);
      test_random(400, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
